// File: rtl/ber_meter_if.sv
// ber_meter_if: enable, sample and readout bundle for one ber_meter channel.  Rev 1.0
`default_nettype none

interface ber_meter_if #(
  parameter int NB_DELAY_LOG = 9,
  parameter int NB_CNT       = 64
);
  logic                    i_enb;
  logic                    i_valid;
  logic                    i_tx_bit;
  logic                    i_rx_bit;
  logic [NB_CNT-1:0]       o_ber_samp;
  logic [NB_CNT-1:0]       o_ber_error;
  logic                    o_aligned;
  logic [NB_DELAY_LOG-1:0] o_delay_sel;

  modport master (
    output i_enb, i_valid, i_tx_bit, i_rx_bit,
    input  o_ber_samp, o_ber_error, o_aligned, o_delay_sel
  );

  modport slave (
    input  i_enb, i_valid, i_tx_bit, i_rx_bit,
    output o_ber_samp, o_ber_error, o_aligned, o_delay_sel
  );
endinterface

`default_nettype wire

// File: rtl/ber_meter.sv
// ber_meter: aligns rx bits to a delayed PRBS reference, then counts samples and bit errors.  Rev 1.0
`default_nettype none

module ber_meter #(
  parameter int NB_DELAY_LOG = 9,
  parameter int ALIGN_WINDOW = 511,
  parameter int NB_CNT       = 64
) (
  input  logic       clk,
  input  logic       i_rst,
  ber_meter_if.slave bus
);
  localparam int DEPTH  = 1 << NB_DELAY_LOG;
  localparam int NB_WIN = $clog2(ALIGN_WINDOW + 1);

  localparam logic [NB_WIN-1:0]       WIN_LAST  = NB_WIN'(ALIGN_WINDOW - 1);
  localparam logic [NB_WIN-1:0]       WIN_ONE   = NB_WIN'(1);
  localparam logic [NB_DELAY_LOG-1:0] CAND_LAST = {NB_DELAY_LOG{1'b1}};
  localparam logic [NB_DELAY_LOG-1:0] CAND_ONE  = NB_DELAY_LOG'(1);
  localparam logic [NB_CNT-1:0]       CNT_MAX   = {NB_CNT{1'b1}};
  localparam logic [NB_CNT-1:0]       CNT_ONE   = NB_CNT'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    COUNT  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [DEPTH-1:0]        dline;
  logic [NB_DELAY_LOG-1:0] cand, cand_nxt;
  logic [NB_DELAY_LOG-1:0] best, best_nxt;
  logic [NB_WIN-1:0]       win_cnt, win_cnt_nxt;
  logic [NB_WIN-1:0]       win_err, win_err_nxt;
  logic [NB_WIN-1:0]       min_err, min_err_nxt;
  logic [NB_WIN-1:0]       win_err_sum;
  logic [NB_CNT-1:0]       samp, samp_nxt;
  logic [NB_CNT-1:0]       errs, errs_nxt;
  logic                    aligned;
  logic                    err_bit;
  logic                    better;

  // cand doubles as the locked delay once in COUNT
  assign err_bit     = bus.i_rx_bit ^ dline[cand];
  assign win_err_sum = win_err + (err_bit ? WIN_ONE : '0);
  assign better      = (win_err_sum < min_err);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      dline <= '0;
    end else if (bus.i_valid) begin
      dline <= {dline[DEPTH-2:0], bus.i_tx_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cand    <= '0;
      best    <= '0;
      win_cnt <= '0;
      win_err <= '0;
      min_err <= '0;
      samp    <= '0;
      errs    <= '0;
      aligned <= 1'b0;
    end else begin
      state   <= state_nxt;
      cand    <= cand_nxt;
      best    <= best_nxt;
      win_cnt <= win_cnt_nxt;
      win_err <= win_err_nxt;
      min_err <= min_err_nxt;
      samp    <= samp_nxt;
      errs    <= errs_nxt;
      aligned <= (state_nxt == COUNT);
    end
  end

  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    best_nxt    = best;
    win_cnt_nxt = win_cnt;
    win_err_nxt = win_err;
    min_err_nxt = min_err;
    samp_nxt    = samp;
    errs_nxt    = errs;

    case (state)
      IDLE: begin
        if (bus.i_enb) begin
          state_nxt   = SEARCH;
          cand_nxt    = '0;
          best_nxt    = '0;
          win_cnt_nxt = '0;
          win_err_nxt = '0;
          min_err_nxt = '1;
          samp_nxt    = '0;
          errs_nxt    = '0;
        end
      end

      SEARCH: begin
        if (!bus.i_enb) begin
          state_nxt = IDLE;
        end else if (bus.i_valid) begin
          if (win_cnt == WIN_LAST) begin
            if (win_err_sum == '0) begin
              state_nxt = COUNT;
            end else begin
              if (better) begin
                min_err_nxt = win_err_sum;
                best_nxt    = cand;
              end
              if (cand == CAND_LAST) begin
                // the last candidate may itself be the new best
                state_nxt = COUNT;
                cand_nxt  = better ? cand : best;
              end else begin
                cand_nxt    = cand + CAND_ONE;
                win_cnt_nxt = '0;
                win_err_nxt = '0;
              end
            end
          end else begin
            win_cnt_nxt = win_cnt + WIN_ONE;
            win_err_nxt = win_err_sum;
          end
        end
      end

      COUNT: begin
        if (!bus.i_enb) begin
          state_nxt = IDLE;
        end else if (bus.i_valid) begin
          if (samp != CNT_MAX) samp_nxt = samp + CNT_ONE;
          if (err_bit && (errs != CNT_MAX)) errs_nxt = errs + CNT_ONE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_ber_samp  = samp;
  assign bus.o_ber_error = errs;
  assign bus.o_aligned   = aligned;
  assign bus.o_delay_sel = cand;

endmodule

`default_nettype wire

// File: tb/tb_ber_meter.sv
// tb_ber_meter: directed scoreboard bench for ber_meter (64-bit and 8-bit counter instances).  Rev 1.0
`default_nettype none

module tb_ber_meter;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  ber_meter_if #(.NB_DELAY_LOG(4), .NB_CNT(64)) bus_a ();
  ber_meter_if #(.NB_DELAY_LOG(4), .NB_CNT(8))  bus_b ();

  ber_meter #(.NB_DELAY_LOG(4), .ALIGN_WINDOW(32), .NB_CNT(64)) dut_a (
    .clk   (clk),
    .i_rst (rst_a),
    .bus   (bus_a)
  );

  ber_meter #(.NB_DELAY_LOG(4), .ALIGN_WINDOW(32), .NB_CNT(8)) dut_b (
    .clk   (clk),
    .i_rst (rst_b),
    .bus   (bus_b)
  );

  typedef struct {
    string       name;
    bit          on_b;
    logic [63:0] samp;
    logic [63:0] errs;
    logic        aligned;
    logic [3:0]  sel;
  } chk_t;

  typedef struct {
    int         vcnt;
    logic [3:0] sel;
  } lock_t;

  chk_t  chk_q[$];
  lock_t lock_qa[$];
  lock_t lock_qb[$];

  int          total   = 0;
  int          bad     = 0;
  bit          chk_req = 1'b0;
  int          vcnt_a  = 0;
  int          vcnt_b  = 0;
  logic [8:0]  lfsr    = 9'h1FF;
  logic [15:0] hist    = '0;
  logic        al_a_d  = 1'b0;
  logic        al_b_d  = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // PRBS9, x^9 + x^5 + 1
  task automatic prbs_step(output logic b);
    b    = lfsr[8] ^ lfsr[4];
    lfsr = {lfsr[7:0], b};
  endtask

  task automatic garbage();
    bus_a.i_valid  = 1'b0;
    bus_b.i_valid  = 1'b0;
    bus_a.i_tx_bit = 1'($urandom_range(0, 1));
    bus_a.i_rx_bit = 1'($urandom_range(0, 1));
    bus_b.i_tx_bit = 1'($urandom_range(0, 1));
    bus_b.i_rx_bit = 1'($urandom_range(0, 1));
  endtask

  // rx = reference delayed by dly+1 valid samples, optionally inverted
  task automatic send(input bit on_b, input int dly, input bit flip);
    logic t;
    logic r;
    prbs_step(t);
    r = hist[dly] ^ flip;
    if (on_b) begin
      bus_b.i_tx_bit = t; bus_b.i_rx_bit = r; bus_b.i_valid = 1'b1;
    end else begin
      bus_a.i_tx_bit = t; bus_a.i_rx_bit = r; bus_a.i_valid = 1'b1;
    end
    @(posedge clk); #1;
    hist = {hist[14:0], t};
    if (on_b) vcnt_b++; else vcnt_a++;
    garbage();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      garbage();
      @(posedge clk); #1;
    end
  endtask

  task automatic set_enb(input bit on_b, input logic v);
    if (on_b) bus_b.i_enb = v; else bus_a.i_enb = v;
    idle(1);
  endtask

  task automatic start(input bit on_b);
    set_enb(on_b, 1'b0);
    set_enb(on_b, 1'b1);
    if (on_b) vcnt_b = 0; else vcnt_a = 0;
  endtask

  task automatic expect_lock(input bit on_b, input int vcnt, input logic [3:0] sel);
    lock_t l;
    l.vcnt = vcnt;
    l.sel  = sel;
    if (on_b) lock_qb.push_back(l); else lock_qa.push_back(l);
  endtask

  task automatic check(input string nm, input bit on_b, input logic [63:0] samp,
                       input logic [63:0] errs, input logic aligned, input logic [3:0] sel);
    chk_t c;
    c.name = nm; c.on_b = on_b; c.samp = samp; c.errs = errs;
    c.aligned = aligned; c.sel = sel;
    chk_q.push_back(c);
    chk_req = 1'b1;
    @(negedge clk); #1;
    chk_req = 1'b0;
  endtask

  always @(negedge clk) begin : mon_chk
    chk_t c;
    if (chk_req) begin
      if (chk_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard: check requested with empty queue");
      end else begin
        c = chk_q.pop_front();
        if (c.on_b) begin
          cmp({c.name, " samp"},    64'(bus_b.o_ber_samp),  c.samp);
          cmp({c.name, " error"},   64'(bus_b.o_ber_error), c.errs);
          cmp({c.name, " aligned"}, 64'(bus_b.o_aligned),   64'(c.aligned));
          cmp({c.name, " delay"},   64'(bus_b.o_delay_sel), 64'(c.sel));
        end else begin
          cmp({c.name, " samp"},    64'(bus_a.o_ber_samp),  c.samp);
          cmp({c.name, " error"},   64'(bus_a.o_ber_error), c.errs);
          cmp({c.name, " aligned"}, 64'(bus_a.o_aligned),   64'(c.aligned));
          cmp({c.name, " delay"},   64'(bus_a.o_delay_sel), 64'(c.sel));
        end
      end
    end
  end

  always @(negedge clk) begin : mon_lock_a
    lock_t l;
    if (bus_a.o_aligned && !al_a_d) begin
      if (lock_qa.size() == 0) begin
        total++; bad++;
        $display("FAIL lock_a: unexpected lock at valid %0d", vcnt_a);
      end else begin
        l = lock_qa.pop_front();
        cmp("lock_a valid index", 64'(vcnt_a), 64'(l.vcnt));
        cmp("lock_a delay", 64'(bus_a.o_delay_sel), 64'(l.sel));
      end
    end
    al_a_d <= bus_a.o_aligned;
  end

  always @(negedge clk) begin : mon_lock_b
    lock_t l;
    if (bus_b.o_aligned && !al_b_d) begin
      if (lock_qb.size() == 0) begin
        total++; bad++;
        $display("FAIL lock_b: unexpected lock at valid %0d", vcnt_b);
      end else begin
        l = lock_qb.pop_front();
        cmp("lock_b valid index", 64'(vcnt_b), 64'(l.vcnt));
        cmp("lock_b delay", 64'(bus_b.o_delay_sel), 64'(l.sel));
      end
    end
    al_b_d <= bus_b.o_aligned;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.i_enb = 1'b0; bus_b.i_enb = 1'b0;
    garbage();
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    check("reset_a", 1'b0, 0, 0, 1'b0, 4'd0);
    check("reset_b", 1'b1, 0, 0, 1'b0, 4'd0);

    // 1: clean link at ref(5), early exit on the sixth window
    expect_lock(1'b0, 192, 4'd5);
    start(1'b0);
    repeat (192) send(1'b0, 5, 1'b0);
    repeat (1000) send(1'b0, 5, 1'b0);
    check("t1_count", 1'b0, 1000, 0, 1'b1, 4'd5);

    // 2: relock, then one error per 100 valids
    expect_lock(1'b0, 192, 4'd5);
    start(1'b0);
    repeat (192) send(1'b0, 5, 1'b0);
    for (int k = 0; k < 1000; k++) send(1'b0, 5, (k % 100) == 99);
    check("t2_count", 1'b0, 1000, 10, 1'b1, 4'd5);

    // 4: half-rate valid in COUNT
    for (int k = 0; k < 100; k++) begin
      send(1'b0, 5, 1'b0);
      idle(1);
    end
    check("t4_gapped", 1'b0, 1100, 10, 1'b1, 4'd5);

    // 3: two errors in every window forces the full sweep
    expect_lock(1'b0, 512, 4'd3);
    start(1'b0);
    for (int k = 0; k < 512; k++) begin
      send(1'b0, 3, (k % 16) == 15);
      if (k == 39) check("t3_searching", 1'b0, 0, 0, 1'b0, 4'd1);
    end
    repeat (64) send(1'b0, 3, 1'b0);
    check("t3_count", 1'b0, 64, 0, 1'b1, 4'd3);

    // 5: disable freezes, re-enable clears and restarts, reset wins
    expect_lock(1'b0, 192, 4'd5);
    start(1'b0);
    repeat (192) send(1'b0, 5, 1'b0);
    repeat (400) send(1'b0, 5, 1'b0);
    check("t5_count", 1'b0, 400, 0, 1'b1, 4'd5);
    set_enb(1'b0, 1'b0);
    check("t5_disabled", 1'b0, 400, 0, 1'b0, 4'd5);
    repeat (3) send(1'b0, 5, 1'b0);
    check("t5_idle_hold", 1'b0, 400, 0, 1'b0, 4'd5);
    set_enb(1'b0, 1'b1);
    check("t5_reenable", 1'b0, 0, 0, 1'b0, 4'd0);
    repeat (40) send(1'b0, 5, 1'b0);
    check("t5_research", 1'b0, 0, 0, 1'b0, 4'd1);
    rst_a = 1'b1;
    bus_a.i_enb = 1'b0;
    idle(1);
    rst_a = 1'b0;
    check("t5_reset", 1'b0, 0, 0, 1'b0, 4'd0);
    repeat (5) send(1'b0, 5, 1'b0);
    check("t5_after_reset", 1'b0, 0, 0, 1'b0, 4'd0);

    // 6: 8-bit counters saturate at 255
    hist = '0;
    expect_lock(1'b1, 96, 4'd2);
    start(1'b1);
    repeat (96) send(1'b1, 2, 1'b0);
    for (int k = 0; k < 600; k++) begin
      send(1'b1, 2, (k % 2) == 1);
      if (k == 199) check("t6_partial", 1'b1, 200, 100, 1'b1, 4'd2);
    end
    check("t6_saturated", 1'b1, 255, 255, 1'b1, 4'd2);

    idle(2);
    cmp("lock_a pending", 64'(lock_qa.size()), 0);
    cmp("lock_b pending", 64'(lock_qb.size()), 0);
    cmp("checks pending", 64'(chk_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
